// File: rtl/tank_map_pkg.sv
// Shared definitions for the tank game tile map: level-1 layout, hit outcomes, writer states.
package tank_map_pkg;

  localparam int MAP_DIM = 16;

  // Level-1 layout. Row y is DEFAULT_MAP[y], column x is bit x of that row; 1 = wall.
  localparam logic [MAP_DIM-1:0][MAP_DIM-1:0] DEFAULT_MAP = {
    16'hFFFF,  // y=15
    16'h8001,  // y=14
    16'h8001,  // y=13
    16'h8C31,  // y=12
    16'h8001,  // y=11
    16'h8001,  // y=10
    16'h8001,  // y=9
    16'h83C1,  // y=8
    16'h83C1,  // y=7
    16'h8001,  // y=6
    16'h8001,  // y=5
    16'h8C31,  // y=4
    16'h8001,  // y=3
    16'h8005,  // y=2
    16'h8001,  // y=1
    16'hFFFF   // y=0
  };

  typedef enum logic [1:0] {
    HIT_ROAD      = 2'd0,
    HIT_DAMAGED   = 2'd1,
    HIT_DESTROYED = 2'd2,
    HIT_STEEL     = 2'd3
  } hit_result_t;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    UPDATE = 2'd2
  } map_state_t;

endpackage

// File: rtl/tile_map_writer.sv
// Writable 16x16 tile map: loads the level layout, applies bullet damage, serves the renderer.
module tile_map_writer
  import tank_map_pkg::*;
#(
  parameter int WALL_HP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_start,
  output logic       init_done,
  input  logic       hit_valid,
  output logic       hit_ready,
  input  logic [3:0] hit_x,
  input  logic [3:0] hit_y,
  output logic       hit_done,
  output logic [1:0] hit_result,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic       rd_wall
);

  localparam logic [1:0] FULL_HP = 2'(WALL_HP);

  logic [1:0]  cells [MAP_DIM][MAP_DIM];

  map_state_t  state, state_next;
  logic [7:0]  init_cnt, init_cnt_next;
  logic [3:0]  hx, hy;
  logic        latch_hit;
  logic        init_done_next;
  logic        done_next;
  hit_result_t result_next;
  logic        wr_en;
  logic [3:0]  wr_x, wr_y;
  logic [1:0]  wr_data;
  logic [1:0]  cur_hp;
  logic        border;

  // Next-state logic: layout loading, hit acceptance and the single read-modify-write cycle.
  always_comb begin
    state_next     = state;
    init_cnt_next  = init_cnt;
    init_done_next = init_done;
    latch_hit      = 1'b0;
    done_next      = 1'b0;
    result_next    = HIT_ROAD;
    hit_ready      = 1'b0;
    wr_en          = 1'b0;
    wr_x           = init_cnt[3:0];
    wr_y           = init_cnt[7:4];
    wr_data        = 2'd0;
    cur_hp         = cells[hy][hx];
    border         = (hx == 4'd0) || (hx == 4'hF) || (hy == 4'd0) || (hy == 4'hF);

    case (state)
      INIT: begin
        wr_en         = 1'b1;
        wr_data       = DEFAULT_MAP[init_cnt[7:4]][init_cnt[3:0]] ? FULL_HP : 2'd0;
        init_cnt_next = init_cnt + 8'd1;
        if (init_cnt == 8'hFF) begin
          state_next     = IDLE;
          init_done_next = 1'b1;
        end
      end
      IDLE: begin
        hit_ready = !init_start;
        if (init_start) begin
          init_done_next = 1'b0;
          init_cnt_next  = 8'd0;
          state_next     = INIT;
        end else if (hit_valid) begin
          latch_hit  = 1'b1;
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        done_next  = 1'b1;
        state_next = IDLE;
        wr_x       = hx;
        wr_y       = hy;
        if (border) begin
          result_next = HIT_STEEL;
        end else if (cur_hp == 2'd0) begin
          result_next = HIT_ROAD;
        end else if (cur_hp == 2'd1) begin
          wr_en       = 1'b1;
          wr_data     = 2'd0;
          result_next = HIT_DESTROYED;
        end else begin
          wr_en       = 1'b1;
          wr_data     = cur_hp - 2'd1;
          result_next = HIT_DAMAGED;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // Control registers: state, load counter, latched hit coordinates and hit outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      init_cnt   <= 8'd0;
      init_done  <= 1'b0;
      hx         <= 4'd0;
      hy         <= 4'd0;
      hit_done   <= 1'b0;
      hit_result <= 2'd0;
    end else begin
      state     <= state_next;
      init_cnt  <= init_cnt_next;
      init_done <= init_done_next;
      hit_done  <= done_next;
      if (latch_hit) begin
        hx <= hit_x;
        hy <= hit_y;
      end
      if (done_next) begin
        hit_result <= result_next;
      end
    end
  end

  // Tile HP storage; a single write port shared by the layout loader and hit updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int y = 0; y < MAP_DIM; y++) begin
        for (int x = 0; x < MAP_DIM; x++) begin
          cells[y][x] <= 2'd0;
        end
      end
    end else if (wr_en) begin
      cells[wr_y][wr_x] <= wr_data;
    end
  end

  // Renderer read port; sees the pre-write value when a hit updates the same tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_wall <= 1'b0;
    end else begin
      rd_wall <= (cells[rd_y][rd_x] != 2'd0);
    end
  end

endmodule

// File: doc/tile_map_writer.md
Name: tile_map_writer

Overview:
- Owns the writable 16x16 tile map that the background renderer reads, and applies bullet-hit damage to wall tiles.
- Loads the level-1 layout after reset or on request. It then accepts hit requests over a valid/ready handshake and performs one read-modify-write per hit.
- Serves a registered read port for the renderer, giving per-tile wall/road status for the tile under the current scan position.

Parameters:
- WALL_HP, 2, hit points loaded into each destructible wall tile at init; legal range 1..3.
- MAP_DIM, 16, tiles per side; fixed at 16 because coordinates are 4 bits wide.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- init_start  input  1  one-cycle request to reload the default layout; sampled only in IDLE.
- init_done  output  1  high once the layout is loaded and the map is serviceable.
- hit_valid  input  1  hit request valid.
- hit_ready  output  1  block can accept a hit this cycle.
- hit_x  input  4  tile column of the hit.
- hit_y  input  4  tile row of the hit.
- hit_done  output  1  one-cycle pulse: the hit has been applied.
- hit_result  output  2  outcome, valid while hit_done: 0 road, 1 damaged, 2 destroyed, 3 indestructible.
- rd_x  input  4  renderer tile column.
- rd_y  input  4  renderer tile row.
- rd_wall  output  1  1 if tile (rd_x, rd_y) currently has HP not equal to 0; registered.

Behaviour:
- Storage: 256 cells of 2-bit HP, indexed [row y][column x]. HP 0 = road, HP nonzero = wall. Async reset clears every cell to 0.
- Reset values: rd_wall=0, hit_done=0, hit_result=0, init_done=0, state=INIT, init counter=0.
- FSM states are INIT, IDLE and UPDATE.
- INIT:
  - 8-bit counter i runs 0..255 over 256 cycles.
  - Each cycle writes cell[i[7:4]][i[3:0]] = DEFAULT_MAP bit ? WALL_HP : 0.
  - hit_ready=0 throughout.
  - After the write of i=255, go to IDLE and set init_done=1.
  - init_done is 0 for the whole of INIT.
- IDLE:
  - hit_ready = (state==IDLE) && !init_start. This is combinational, so init_start has priority over a same-cycle hit.
  - If init_start: clear init_done, counter=0, go to INIT.
  - Else if hit_valid && hit_ready: latch hit_x and hit_y, go to UPDATE.
- UPDATE (exactly one cycle):
  - Read cell c at the latched coordinates and compute the result.
  - Border cell (x or y equal to 0 or 15): no write, result 3.
  - c==0: no write, result 0.
  - c==1: write 0, result 2.
  - c>1: write c-1, result 1.
  - The decrement uses 2-bit unsigned arithmetic and never underflows.
  - Register hit_done=1 and hit_result, then return to IDLE.
- Latency: handshake accepted at edge T; hit_done is high for the single cycle after edge T+1. hit_ready is 0 for that one cycle (UPDATE) and back to 1 in the hit_done cycle.
- Back-to-back: a new hit may be accepted in the same cycle hit_done is high. Maximum throughput is one hit per 2 cycles.
- hit_result holds its value between pulses. hit_done is 0 in every cycle that does not follow an UPDATE.
- Read port:
  - rd_wall <= (cell[rd_y][rd_x] != 0) every cycle in all states, with 1-cycle latency.
  - A read of a cell being written by UPDATE in the same cycle returns the pre-write value.
  - During INIT, rd_wall reflects partially loaded content; the renderer gates on init_done.
- Reset mid-INIT or mid-UPDATE: all state is cleared immediately and the block restarts INIT from 0. An in-flight hit is lost, with no hit_done.
- The border check uses coordinates only; border tiles never lose HP.

Decomposition:
- Package tank_map_pkg holds:
  - DEFAULT_MAP, a 16x16 logic constant for the level-1 layout: all border tiles are walls, (x=1,y=1) is road, (x=2,y=2) is wall.
  - typedef hit_result_t, an enum {HIT_ROAD, HIT_DAMAGED, HIT_DESTROYED, HIT_STEEL}.
  - the state enum {INIT, IDLE, UPDATE}.
- No sub-module: storage, FSM and read port stay in one module. The renderer imports tank_map_pkg for DEFAULT_MAP and MAP_DIM.

Test Plan:
- Reset, then wait 256 cycles. Expect init_done=1 and hit_ready=1 exactly 256 cycles after rst falls; rd (0,0) gives rd_wall=1 and rd (1,1) gives rd_wall=0, each one cycle after address.
- Hit (2,2) with WALL_HP=2. First hit gives hit_done 2 cycles after accept with result 1 and rd_wall(2,2)=1. Second hit gives result 2 and rd_wall(2,2)=0. Third hit gives result 0.
- Hit (0,5) and (15,15). Both give result 3; rd_wall stays 1; no cell changes.
- Hold hit_valid high with 4 different coordinates. Expect accepts every 2nd cycle, 4 hit_done pulses on alternating cycles, and hit_ready low only in UPDATE cycles.
- Assert init_start and hit_valid together in IDLE. The hit is not accepted, init_done drops to 0, and 256 cycles later the previously destroyed (2,2) reads rd_wall=1 again.
- Assert rst during UPDATE of hit (2,2). No hit_done, all outputs 0, and the map reloads with (2,2) at full HP.
